// File: rtl/spi_slave_regfile_cmd.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_regfile_cmd
// Description : SPI command decoder between the mode-3 SPI byte driver and the
//               pulse controller. It does the following:
//                 - writes an indexed register file, committing only after an
//                   XOR checksum matches
//                 - serves register readback and a multi-byte feedback snapshot
//                 - stretches every ack pulse so a slower clock domain can
//                   sample it
// Ports       : clk, rst_n        core clock, async active-low reset
//               cs_n              chip select (already synchronised)
//               rx_byte/rx_valid  received byte and its 1-cycle strobe
//               tx_byte           next response byte for the SPI driver
//               reg_data          flat register file image
//               reg_ack           per-register commit ack (stretched)
//               start_ack/stop_ack start/stop command acks (stretched)
//               fb_data_async     feedback word from the other domain
//               fb_update         "feedback word stable" flag from that domain
//               err_cnt           saturating rejected-frame counter
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_regfile_cmd #(
  parameter int NUM_REGS   = 4,
  parameter int DATA_BYTES = 2,
  parameter int FB_BYTES   = 4,
  parameter int ACK_CYCLES = 4,
  parameter logic [NUM_REGS*8*DATA_BYTES-1:0] RESET_VALUES = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cs_n,
  input  logic [7:0]                     rx_byte,
  input  logic                           rx_valid,
  output logic [7:0]                     tx_byte,
  output logic [NUM_REGS*8*DATA_BYTES-1:0] reg_data,
  output logic [NUM_REGS-1:0]            reg_ack,
  output logic                           start_ack,
  output logic                           stop_ack,
  input  logic [8*FB_BYTES-1:0]          fb_data_async,
  input  logic                           fb_update,
  output logic [7:0]                     err_cnt
);

  localparam int RW   = 8 * DATA_BYTES;
  localparam int MAXB = (DATA_BYTES > FB_BYTES) ? DATA_BYTES : FB_BYTES;
  localparam int SW   = 8 * MAXB;
  localparam int CW   = $clog2(MAXB + 1);
  localparam int AW   = $clog2(ACK_CYCLES + 1);
  localparam int NACK = NUM_REGS + 2;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PULSE   = 3'd1;
  localparam logic [2:0] S_WR_DATA = 3'd2;
  localparam logic [2:0] S_WR_CHK  = 3'd3;
  localparam logic [2:0] S_RD      = 3'd4;
  localparam logic [2:0] S_FB      = 3'd5;
  localparam logic [2:0] S_DISCARD = 3'd6;

  logic [2:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [7:0]          tx_q, tx_d;
  logic [SW-1:0]       stream_q, stream_d;   // bytes still to be sent, LSB next
  logic [RW-1:0]       shadow_q, shadow_d;
  logic [7:0]          chk_q, chk_d;
  logic [4:0]          widx_q, widx_d;
  logic                is_start_q, is_start_d;
  logic                commit_q, commit_d;
  logic                cs_prev_q;
  logic [2:0]          sync_q;
  logic [8*FB_BYTES-1:0] snap_q;
  logic [7:0]          err_q;
  logic                err_inc;

  logic                w_cs_rise;
  logic                w_idx_ok;
  logic [RW-1:0]       w_rd_word;
  logic [RW+7:0]       w_shift;
  logic [NACK-1:0]     w_pulse;
  logic [NACK-1:0]     w_ack;

  assign w_cs_rise = cs_n & ~cs_prev_q;
  assign w_idx_ok  = int'(rx_byte[4:0]) < NUM_REGS;
  // Payload arrives LSB first: shift each byte in from the top.
  assign w_shift   = {rx_byte, shadow_q};

  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rx_byte[4:0] == 5'(i)) w_rd_word = reg_data[i*RW +: RW];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_d       = tx_q;
    stream_d   = stream_q;
    shadow_d   = shadow_q;
    chk_d      = chk_q;
    widx_d     = widx_q;
    is_start_d = is_start_q;
    commit_d   = 1'b0;
    err_inc    = 1'b0;
    if (state_q == S_IDLE) cnt_d = '0;
    if (w_cs_rise && state_q != S_IDLE) begin
      // Frame aborted: any byte in this cycle is dropped, shadow is abandoned.
      state_d = S_IDLE;
      tx_d    = 8'hFF;
      cnt_d   = '0;
      err_inc = (state_q == S_WR_DATA) || (state_q == S_WR_CHK);
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rx_valid && !w_cs_rise) begin
            if (rx_byte == 8'h06 || rx_byte == 8'h04) begin
              state_d    = S_PULSE;
              is_start_d = rx_byte[1];
            end else if (rx_byte[7:5] == 3'b100 && w_idx_ok) begin
              state_d = S_WR_DATA;
              widx_d  = rx_byte[4:0];
              chk_d   = rx_byte;
            end else if (rx_byte[7:5] == 3'b110 && w_idx_ok) begin
              state_d  = S_RD;
              tx_d     = w_rd_word[7:0];
              stream_d = SW'(w_rd_word) >> 8;
            end else if (rx_byte == 8'hAB) begin
              state_d  = S_FB;
              tx_d     = snap_q[7:0];
              stream_d = SW'(snap_q) >> 8;
            end else begin
              state_d = S_DISCARD;
              err_inc = 1'b1;
            end
          end
        end
        S_PULSE: state_d = S_IDLE;
        S_WR_DATA: begin
          if (rx_valid) begin
            shadow_d = w_shift[RW+7:8];
            chk_d    = chk_q ^ rx_byte;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(DATA_BYTES - 1)) state_d = S_WR_CHK;
          end
        end
        S_WR_CHK: begin
          if (rx_valid) begin
            if (rx_byte == chk_q) commit_d = 1'b1;
            else                  err_inc  = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_RD, S_FB: begin
          if (rx_valid) begin
            if ((state_q == S_RD && cnt_q == CW'(DATA_BYTES - 1)) ||
                (state_q == S_FB && cnt_q == CW'(FB_BYTES - 1))) begin
              state_d = S_IDLE;
              tx_d    = 8'hFF;
            end else begin
              tx_d     = stream_q[7:0];
              stream_d = stream_q >> 8;
              cnt_d    = cnt_q + 1'b1;
            end
          end
        end
        S_DISCARD: if (cs_n) state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      tx_q       <= 8'hFF;
      stream_q   <= '0;
      shadow_q   <= '0;
      chk_q      <= '0;
      widx_q     <= '0;
      is_start_q <= 1'b0;
      commit_q   <= 1'b0;
      cs_prev_q  <= 1'b1;  // deselected, so reset release is not seen as a rise
      sync_q     <= '0;
      snap_q     <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_q       <= tx_d;
      stream_q   <= stream_d;
      shadow_q   <= shadow_d;
      chk_q      <= chk_d;
      widx_q     <= widx_d;
      is_start_q <= is_start_d;
      commit_q   <= commit_d;
      cs_prev_q  <= cs_n;
      sync_q     <= {sync_q[1:0], fb_update};
      // Snapshot only between frames so a readout is never torn.
      if (sync_q[2] && cs_n) snap_q <= fb_data_async;
      if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
    end
  end

  genvar g;
  for (g = 0; g < NUM_REGS; g++) begin : g_reg
    logic [RW-1:0] val_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                val_q <= RESET_VALUES[g*RW +: RW];
      else if (commit_q && widx_q == 5'(g))      val_q <= shadow_q;
    end
    assign reg_data[g*RW +: RW] = val_q;
    assign w_pulse[g] = commit_q && (widx_q == 5'(g));
  end

  assign w_pulse[NUM_REGS]     = (state_q == S_PULSE) && !w_cs_rise && is_start_q;
  assign w_pulse[NUM_REGS + 1] = (state_q == S_PULSE) && !w_cs_rise && !is_start_q;

  // Each ack reloads its hold counter on a pulse edge, so back-to-back
  // triggers extend the hold without a gap.
  for (g = 0; g < NACK; g++) begin : g_ack
    logic [AW-1:0] hold_q;
    logic          prev_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold_q <= '0;
        prev_q <= 1'b0;
      end else begin
        prev_q <= w_pulse[g];
        if (w_pulse[g] && !prev_q) hold_q <= AW'(ACK_CYCLES);
        else if (hold_q != '0)     hold_q <= hold_q - 1'b1;
      end
    end
    assign w_ack[g] = (hold_q != '0);
  end

  assign reg_ack   = w_ack[NUM_REGS-1:0];
  assign start_ack = w_ack[NUM_REGS];
  assign stop_ack  = w_ack[NUM_REGS + 1];
  assign tx_byte   = tx_q;
  assign err_cnt   = err_q;

endmodule
`default_nettype wire
